riscv_trace_buffer: RTL and testbench

Circular commit-trace buffer that sits beside the `riscv` core and records register write-back events (pc, destination address, result) into a parametrised-depth ring. It supports arm/stop control, an optional pc-match trigger with post-trigger capture, and a valid/ready readout port. Benches use it to check instruction streams in bulk, and debug logic can read it back after a freeze.

---
 rtl/riscv_trace_buffer_if.sv | 31 +++
 rtl/riscv_trace_buffer.sv | 140 ++++++++++++++
 tb/tb_riscv_trace_buffer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_trace_buffer_if.sv
// riscv_trace_buffer_if: commit-trace bus into the trace buffer plus the
// valid/ready readout port back out of it.
//   master: the core/consumer side (drives commit fields and rd_ready)
//   slave : the trace buffer (samples commits, presents the head record)
interface riscv_trace_buffer_if #(
  parameter int RegBits  = 32,
  parameter int AddrBits = 5
);
  // commit (write-back) stream
  logic                enable;
  logic [RegBits-1:0]  pc;
  logic                reg_write;
  logic [AddrBits-1:0] write_back;
  logic [RegBits-1:0]  result;
  // readout stream
  logic                rd_valid;
  logic                rd_ready;
  logic [RegBits-1:0]  rd_pc;
  logic [AddrBits-1:0] rd_addr;
  logic [RegBits-1:0]  rd_data;

  modport master (
    output enable, pc, reg_write, write_back, result, rd_ready,
    input  rd_valid, rd_pc, rd_addr, rd_data
  );

  modport slave (
    input  enable, pc, reg_write, write_back, result, rd_ready,
    output rd_valid, rd_pc, rd_addr, rd_data
  );
endinterface

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: circular commit-trace ring recording (pc, rd, result)
// for every non-x0 register write-back while capturing. Arm clears and starts
// capture, stop freezes it; once frozen the ring is drained oldest-first
// through the valid/ready readout port.
// Optional pc-match trigger with post-trigger capture: RISCV_TRACE_TRIGGER_EN.
module riscv_trace_buffer #(
  parameter int RegBits     = 32,
  parameter int AddrBits    = 5,
  parameter int Depth       = 16,
  parameter int PostTrigger = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  riscv_trace_buffer_if.slave        bus,
  input  logic                       arm_i,
  input  logic                       stop_i,
  input  logic [RegBits-1:0]         trigger_pc_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       overflow_o,
  output logic [1:0]                 state_o
);

  localparam int PtrBits = $clog2(Depth);
  localparam int CntBits = PtrBits + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  state_t              state;
  logic [PtrBits-1:0]  head;
  logic [PtrBits-1:0]  tail;
  logic [PtrBits-1:0]  post_cnt;
  logic [CntBits-1:0]  count;
  logic                overflow;

  logic [RegBits-1:0]  ring_pc   [Depth];
  logic [AddrBits-1:0] ring_addr [Depth];
  logic [RegBits-1:0]  ring_data [Depth];

  logic capturing;
  logic cap_event;
  logic full;
  logic rd_valid;
  logic pop;
  logic trig_hit;
  logic post_done;

  assign capturing = (state == CAPTURE) || (state == POST);
  // x0 writes carry no architectural information and are never recorded
  assign cap_event = capturing && bus.enable && bus.reg_write &&
                     (bus.write_back != '0);
  assign full      = (count == CntBits'(Depth));
  // readout is only offered while the ring is not being written
  assign rd_valid  = (count != '0) && ((state == IDLE) || (state == FROZEN));
  assign pop       = rd_valid && bus.rd_ready;

`ifdef RISCV_TRACE_TRIGGER_EN
  // the trigger record itself is stored; the post counter starts after it
  assign trig_hit  = cap_event && (state == CAPTURE) && (bus.pc == trigger_pc_i);
  assign post_done = cap_event && (state == POST) &&
                     ((CntBits'(post_cnt) + 1'b1) == CntBits'(PostTrigger));
`else
  assign trig_hit  = 1'b0;
  assign post_done = 1'b0;
  logic unused_trigger;
  assign unused_trigger = ^{trigger_pc_i, post_cnt, PostTrigger[0]};
`endif

  // control FSM with ring pointers, occupancy, overflow and post counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else if (arm_i) begin
      state    <= CAPTURE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else begin
      // events and pops are mutually exclusive: pops need a non-capture state
      if (cap_event) begin
        tail <= tail + 1'b1;
        if (full) begin
          head     <= head + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (pop) begin
        head  <= head + 1'b1;
        count <= count - 1'b1;
      end

      case (state)
        CAPTURE: begin
          if (stop_i) begin
            state <= FROZEN;
          end else if (trig_hit) begin
            state    <= POST;
            post_cnt <= '0;
          end
        end
        POST: begin
          if (cap_event) post_cnt <= post_cnt + 1'b1;
          if (stop_i || post_done) state <= FROZEN;
        end
        default: ;
      endcase
    end
  end

  // ring storage, written at the tail on each capture event
  always_ff @(posedge clk_i) begin
    if (cap_event) begin
      ring_pc[tail]   <= bus.pc;
      ring_addr[tail] <= bus.write_back;
      ring_data[tail] <= bus.result;
    end
  end

  assign bus.rd_valid = rd_valid;
  assign bus.rd_pc    = rd_valid ? ring_pc[head]   : '0;
  assign bus.rd_addr  = rd_valid ? ring_addr[head] : '0;
  assign bus.rd_data  = rd_valid ? ring_data[head] : '0;

  assign count_o    = count;
  assign overflow_o = overflow;
  assign state_o    = state;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: directed scoreboard bench for riscv_trace_buffer.
// Stimulus pushes the hand-computed records it expects to read back; a
// negedge monitor pops and compares every accepted readout record.
module tb_riscv_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        arm_i;
  logic        stop_i;
  logic [31:0] trigger_pc_i;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [1:0]  state_o;

  riscv_trace_buffer_if #(.RegBits(32), .AddrBits(5)) bus ();

  riscv_trace_buffer #(
    .RegBits(32), .AddrBits(5), .Depth(16), .PostTrigger(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .bus          (bus),
    .arm_i        (arm_i),
    .stop_i       (stop_i),
    .trigger_pc_i (trigger_pc_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_rec;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // monitor: every record accepted by the consumer must match the scoreboard head
  always @(negedge clk) begin
    if (rst_i === 1'b1 && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc=0x%0h data=0x%0h expected no record",
                 bus.rd_pc, bus.rd_data);
      end else begin
        mon_rec = exp_q.pop_front();
        $display("pop pc=0x%0h addr=%0d data=0x%0h", bus.rd_pc, bus.rd_addr, bus.rd_data);
        check("rd_pc", bus.rd_pc, mon_rec.pc);
        check("rd_addr", bus.rd_addr, mon_rec.addr);
        check("rd_data", bus.rd_data, mon_rec.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                        input logic en = 1'b1, input logic we = 1'b1);
    bus.enable     = en;
    bus.reg_write  = we;
    bus.pc         = pc;
    bus.write_back = rd;
    bus.result     = data;
    step();
    bus.enable    = 1'b0;
    bus.reg_write = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    rec_t r;
    r.pc   = pc;
    r.addr = rd;
    r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic do_arm();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 40 && bus.rd_valid === 1'b1; i++) step();
    bus.rd_ready = 1'b0;
    check({name, "_valid_low"}, bus.rd_valid, 1'b0);
    check({name, "_rd_data_zero"}, bus.rd_data, 32'h0);
    check({name, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_i          = 1'b0;
    arm_i          = 1'b0;
    stop_i         = 1'b0;
    trigger_pc_i   = 32'hFFFF_FFFF;
    bus.enable     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.pc         = '0;
    bus.write_back = '0;
    bus.result     = '0;
    bus.rd_ready   = 1'b0;

    // reset state
    repeat (3) step();
    check("reset_state", state_o, 2'd0);
    check("reset_count", count_o, 5'd0);
    check("reset_overflow", overflow_o, 1'b0);
    check("reset_valid", bus.rd_valid, 1'b0);
    check("reset_rd_pc", bus.rd_pc, 32'h0);
    rst_i = 1'b1;
    step();

    // basic capture: three records, read back in order
    do_arm();
    check("basic_armed_state", state_o, 2'd1);
    check("basic_armed_count", count_o, 5'd0);
    commit(32'h0, 5'd1, 32'hA);
    check("basic_count_after_one", count_o, 5'd1);
    commit(32'h4, 5'd2, 32'hB);
    commit(32'h8, 5'd3, 32'hC);
    check("basic_capture_count", count_o, 5'd3);
    check("basic_no_valid_capturing", bus.rd_valid, 1'b0);
    do_stop();
    check("basic_frozen_state", state_o, 2'd3);
    check("basic_frozen_count", count_o, 5'd3);
    check("basic_frozen_valid", bus.rd_valid, 1'b1);
    push(32'h0, 5'd1, 32'hA);
    push(32'h4, 5'd2, 32'hB);
    push(32'h8, 5'd3, 32'hC);
    drain("basic");
    check("basic_drained_count", count_o, 5'd0);

    // filtering: x0 target, no write strobe, capture disabled
    do_arm();
    commit(32'h10, 5'd0, 32'h1);
    commit(32'h14, 5'd5, 32'h2, 1'b1, 1'b0);
    commit(32'h18, 5'd5, 32'h3, 1'b0, 1'b1);
    check("filter_count", count_o, 5'd0);
    do_stop();
    check("filter_frozen_valid", bus.rd_valid, 1'b0);

    // wrap/overflow: 20 events into a 16-entry ring
    do_arm();
    for (int i = 0; i < 20; i++) commit(32'(i * 4), 5'((i % 31) + 1), 32'(i));
    do_stop();
    check("wrap_count", count_o, 5'd16);
    check("wrap_overflow", overflow_o, 1'b1);
    check("wrap_state", state_o, 2'd3);
    check("wrap_head_data", bus.rd_data, 32'd4);
    for (int i = 4; i < 20; i++) push(32'(i * 4), 5'((i % 31) + 1), 32'(i));
    drain("wrap");

    // priority: arm beats stop in the same cycle
    do_arm();
    commit(32'h20, 5'd4, 32'h44);
    commit(32'h24, 5'd6, 32'h66);
    arm_i  = 1'b1;
    stop_i = 1'b1;
    step();
    arm_i  = 1'b0;
    stop_i = 1'b0;
    check("prio_arm_state", state_o, 2'd1);
    check("prio_arm_count", count_o, 5'd0);
    check("prio_arm_overflow", overflow_o, 1'b0);

    // priority: an event together with stop is still recorded
    stop_i = 1'b1;
    commit(32'h100, 5'd7, 32'hDEAD);
    stop_i = 1'b0;
    check("prio_stop_state", state_o, 2'd3);
    check("prio_stop_count", count_o, 5'd1);
    push(32'h100, 5'd7, 32'hDEAD);
    drain("prio_stop");

    // trigger stimulus: trigger at pc 0x40, events at pc 0x0..0x7C
    trigger_pc_i = 32'h40;
    do_arm();
    for (int i = 0; i < 32; i++) commit(32'(i * 4), 5'((i % 31) + 1), 32'(i));
`ifdef RISCV_TRACE_TRIGGER_EN
    // 16 pre/trigger records + 8 post records: last stored pc is 0x60
    check("trig_state", state_o, 2'd3);
    check("trig_count", count_o, 5'd16);
    check("trig_overflow", overflow_o, 1'b1);
    check("trig_head_pc", bus.rd_pc, 32'h24);
    for (int i = 9; i < 25; i++) push(32'(i * 4), 5'((i % 31) + 1), 32'(i));
    drain("trig");
`else
    check("notrig_state", state_o, 2'd1);
    check("notrig_count", count_o, 5'd16);
    check("notrig_overflow", overflow_o, 1'b1);
    do_stop();
    for (int i = 16; i < 32; i++) push(32'(i * 4), 5'((i % 31) + 1), 32'(i));
    drain("notrig");
`endif
    trigger_pc_i = 32'hFFFF_FFFF;

    // asynchronous reset mid-capture, observed before any clock edge
    do_arm();
    commit(32'h200, 5'd8, 32'h1);
    commit(32'h204, 5'd9, 32'h2);
    check("async_pre_count", count_o, 5'd2);
    #2;
    rst_i = 1'b0;
    #1;
    check("async_state", state_o, 2'd0);
    check("async_count", count_o, 5'd0);
    check("async_overflow", overflow_o, 1'b0);
    check("async_valid", bus.rd_valid, 1'b0);
    step();
    rst_i = 1'b1;
    step();
    check("async_after_state", state_o, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
